// File: rtl/sha256_stream_padder.sv
// Streams IN_BYTES-wide beats into 512-bit SHA-256 blocks and applies FIPS 180-4 padding.
// Defining SHA_PAD_ABORT_EN adds an abort input that cancels the message in progress.
module sha256_stream_padder #(
    parameter int IN_BYTES = 4,
    parameter int LEN_W    = 64
) (
    input  logic                      clk,
    input  logic                      rst,
`ifdef SHA_PAD_ABORT_EN
    input  logic                      abort,
`endif
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [IN_BYTES*8-1:0]     s_data,
    input  logic                      s_last,
    input  logic [$clog2(IN_BYTES):0] s_nbytes,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [511:0]              m_block,
    output logic                      m_first,
    output logic                      m_last,
    output logic                      busy
);

    localparam int DW = IN_BYTES * 8;

    typedef enum logic [1:0] {ACC, PAD, OUT, XTRA} state_t;

    state_t           state_reg, state_next;
    logic [511:0]     buf_reg, buf_next;
    logic [6:0]       idx_reg, idx_next;
    logic [LEN_W-1:0] len_reg, len_next;
    logic             sent_reg, sent_next;     // a block of this message was already handed off
    logic             last_reg, last_next;
    logic             pend_reg, pend_next;
    logic             pend80_reg, pend80_next; // extra block starts with 0x80 (exact-fill case)

    logic             abort_i;
    logic             beat;
    logic [6:0]       nb;
    logic [6:0]       idx_sum;
    logic [DW-1:0]    beat_mask;
    logic [511:0]     data_sh, mask_sh, buf_wr;
    logic [511:0]     pad_bytes, pad_block, xtra_block;
    logic [63:0]      len64;

`ifdef SHA_PAD_ABORT_EN
    assign abort_i = abort;
`else
    assign abort_i = 1'b0;
`endif

    assign s_ready = (state_reg == ACC) && !rst && !abort_i;
    assign beat    = s_valid && s_ready;
    assign nb      = s_last ? 7'(s_nbytes) : 7'(IN_BYTES);
    assign idx_sum = idx_reg + nb;
    assign len64   = 64'(len_reg);

    // Only the first nb bytes of the beat land in the buffer; the rest stay untouched.
    assign beat_mask = ~({DW{1'b1}} >> {nb, 3'b000});
    assign data_sh   = {s_data, {(512-DW){1'b0}}} >> {idx_reg, 3'b000};
    assign mask_sh   = {beat_mask, {(512-DW){1'b0}}} >> {idx_reg, 3'b000};
    assign buf_wr    = (buf_reg & ~mask_sh) | (data_sh & mask_sh);

    genvar gi;
    generate
        for (gi = 0; gi < 64; gi++) begin : g_pad
            localparam logic [6:0] BI = 7'(gi);
            assign pad_bytes[511-8*gi -: 8] = (BI < idx_reg)  ? buf_reg[511-8*gi -: 8] :
                                              (BI == idx_reg) ? 8'h80 : 8'h00;
        end
    endgenerate

    assign pad_block  = (idx_reg < 7'd56) ? {pad_bytes[511:64], len64} : pad_bytes;
    assign xtra_block = {(pend80_reg ? 8'h80 : 8'h00), 440'd0, len64};

    always_comb begin
        state_next  = state_reg;
        buf_next    = buf_reg;
        idx_next    = idx_reg;
        len_next    = len_reg;
        sent_next   = sent_reg;
        last_next   = last_reg;
        pend_next   = pend_reg;
        pend80_next = pend80_reg;
        case (state_reg)
            ACC: begin
                if (beat) begin
                    buf_next = buf_wr;
                    idx_next = idx_sum;
                    len_next = len_reg + (LEN_W'(nb) << 3);
                    if (idx_sum == 7'd64) begin
                        state_next = OUT;
                        last_next  = 1'b0;
                        if (s_last) begin
                            pend_next   = 1'b1;
                            pend80_next = 1'b1;
                        end
                    end else if (s_last) begin
                        state_next = PAD;
                    end
                end
            end
            PAD: begin
                buf_next   = pad_block;
                state_next = OUT;
                if (idx_reg < 7'd56) begin
                    last_next = 1'b1;
                end else begin
                    last_next   = 1'b0;
                    pend_next   = 1'b1;
                    pend80_next = 1'b0;
                end
            end
            OUT: begin
                if (m_ready) begin
                    sent_next = 1'b1;
                    if (pend_reg) begin
                        state_next = XTRA;
                        pend_next  = 1'b0;
                    end else begin
                        state_next = ACC;
                        idx_next   = 7'd0;
                        buf_next   = '0;
                        if (last_reg) begin
                            len_next  = '0;
                            sent_next = 1'b0;
                            last_next = 1'b0;
                        end
                    end
                end
            end
            XTRA: begin
                buf_next   = xtra_block;
                last_next  = 1'b1;
                state_next = OUT;
            end
            default: state_next = ACC;
        endcase
        if (abort_i) begin
            state_next = ACC;
            buf_next   = '0;
            idx_next   = 7'd0;
            len_next   = '0;
            sent_next  = 1'b0;
            last_next  = 1'b0;
            pend_next  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= ACC;
            buf_reg    <= '0;
            idx_reg    <= 7'd0;
            len_reg    <= '0;
            sent_reg   <= 1'b0;
            last_reg   <= 1'b0;
            pend_reg   <= 1'b0;
            pend80_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            buf_reg    <= buf_next;
            idx_reg    <= idx_next;
            len_reg    <= len_next;
            sent_reg   <= sent_next;
            last_reg   <= last_next;
            pend_reg   <= pend_next;
            pend80_reg <= pend80_next;
        end
    end

    assign m_valid = (state_reg == OUT);
    assign m_block = buf_reg;
    assign m_first = m_valid && !sent_reg;
    assign m_last  = last_reg;
    assign busy    = (state_reg != ACC) || (idx_reg != 7'd0);

endmodule

// File: tb/tb_sha256_stream_padder.sv
// Bench for sha256_stream_padder: directed and random messages against a FIPS 180-4 padding model.
`timescale 1ns/1ps
module tb_sha256_stream_padder;
    localparam int IB  = 4;
    localparam int DW  = IB * 8;
    localparam int NBW = $clog2(IB) + 1;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           s_valid = 1'b0;
    logic           s_ready;
    logic [DW-1:0]  s_data = '0;
    logic           s_last = 1'b0;
    logic [NBW-1:0] s_nbytes = '0;
    logic           m_valid;
    logic           m_ready = 1'b0;
    logic [511:0]   m_block;
    logic           m_first, m_last, busy;
`ifdef SHA_PAD_ABORT_EN
    logic           abort = 1'b0;
`endif

    int tests = 0;
    int fails = 0;
    int cyc_cnt = 0;
    byte unsigned msg_q[$];
    logic [511:0] exp_blk[$];
    logic [511:0] cap_blk[$];
    int           exp_kind[$];   // 0: full data block, 1: block holding the 0x80, 2: extra block

    sha256_stream_padder #(.IN_BYTES(IB), .LEN_W(64)) dut (
        .clk      (clk),
        .rst      (rst),
`ifdef SHA_PAD_ABORT_EN
        .abort    (abort),
`endif
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .s_last   (s_last),
        .s_nbytes (s_nbytes),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_block  (m_block),
        .m_first  (m_first),
        .m_last   (m_last),
        .busy     (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Padded message = msg, 0x80, zeros to 56 mod 64, 64-bit big-endian bit length.
    task automatic build_expect();
        byte unsigned p[$];
        logic [63:0]  bl;
        logic [511:0] blk;
        int n;
        n = msg_q.size();
        exp_blk.delete();
        exp_kind.delete();
        cap_blk.delete();
        p = msg_q;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        bl = 64'(n) * 64'd8;
        for (int i = 7; i >= 0; i--) p.push_back(bl[8*i +: 8]);
        for (int b = 0; b < p.size() / 64; b++) begin
            for (int i = 0; i < 64; i++) blk[511 - 8*i -: 8] = p[b*64 + i];
            exp_blk.push_back(blk);
            if (b < n / 64)       exp_kind.push_back(0);
            else if (b == n / 64) exp_kind.push_back((n > 0 && n % 64 == 0) ? 2 : 1);
            else                  exp_kind.push_back(2);
        end
    endtask

    task automatic drive_beat(input int k, input int nbeats, input int n);
        for (int j = 0; j < IB; j++)
            s_data[(IB-1-j)*8 +: 8] = (k*IB + j < n) ? msg_q[k*IB + j] : 8'($urandom);
        s_last   = (k == nbeats - 1);
        s_nbytes = s_last ? NBW'(n - k*IB) : NBW'($urandom_range(0, IB));
    endtask

    // Streams msg_q through the DUT; hold>=0 stalls each block that many cycles, hold<0 is random.
    task automatic run_msg(input string tag, input int hold, input bit gaps);
        int n, nbeats, beat_i, blk_i, stall, t0, last_beat_edge, last_hs_edge, ref_edge;
        bit shown, presented;
        n = msg_q.size();
        nbeats = (n == 0) ? 1 : (n + IB - 1) / IB;
        beat_i = 0; blk_i = 0; stall = 0; shown = 0; presented = 0;
        last_beat_edge = 0; last_hs_edge = 0;
        t0 = cyc_cnt;
        build_expect();
        while (blk_i < exp_blk.size()) begin
            @(negedge clk);
            if (cyc_cnt - t0 > 5000) begin
                check({tag, " timeout blocks"}, 512'(blk_i), 512'(exp_blk.size()));
                break;
            end
            if (m_valid) begin
                if (!shown) begin
                    shown = 1;
                    cap_blk.push_back(m_block);
                    check({tag, " block"}, m_block, exp_blk[blk_i]);
                    check({tag, " first"}, 512'(m_first), 512'(blk_i == 0));
                    check({tag, " last"}, 512'(m_last), 512'(blk_i == exp_blk.size() - 1));
                    ref_edge = (exp_kind[blk_i] == 2) ? last_hs_edge : last_beat_edge;
                    check({tag, " latency"}, 512'(cyc_cnt - ref_edge),
                          512'((exp_kind[blk_i] == 0) ? 0 : 1));
                    stall = (hold >= 0) ? hold : $urandom_range(0, 3);
                end else begin
                    check({tag, " held block"}, m_block, exp_blk[blk_i]);
                    check({tag, " held s_ready"}, 512'(s_ready), '0);
                end
                if (stall > 0) begin
                    m_ready = 1'b0;
                    stall--;
                end else begin
                    m_ready = 1'b1;
                    last_hs_edge = cyc_cnt + 1;
                    blk_i++;
                    shown = 0;
                end
            end else begin
                m_ready = 1'($urandom_range(0, 1));
            end
            if (beat_i < nbeats) begin
                if (!presented && gaps && $urandom_range(0, 3) == 0) begin
                    s_valid = 1'b0;
                end else begin
                    if (!presented) drive_beat(beat_i, nbeats, n);
                    presented = 1;
                    s_valid = 1'b1;
                    if (s_ready) begin
                        beat_i++;
                        presented = 0;
                        last_beat_edge = cyc_cnt + 1;
                    end
                end
            end else begin
                s_valid = 1'b0;
            end
        end
        @(negedge clk);
        s_valid = 1'b0;
        m_ready = 1'b0;
        check({tag, " idle busy"}, 512'(busy), '0);
        check({tag, " idle m_valid"}, 512'(m_valid), '0);
        $display("[TB] %s: %0d bytes, %0d blocks", tag, n, cap_blk.size());
    endtask

    task automatic push_beats(input int count);
        for (int k = 0; k < count; k++) begin
            @(negedge clk);
            s_valid = 1'b1;
            s_last  = 1'b0;
            s_data  = DW'($urandom);
            s_nbytes = '0;
            check("push s_ready", 512'(s_ready), 512'(1));
        end
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic load_msg(input int len);
        msg_q.delete();
        for (int i = 0; i < len; i++) msg_q.push_back(8'($urandom));
    endtask

    initial begin
        logic [511:0] t1_blk, c;
        t1_blk = '0;
        t1_blk[511:480] = 32'h61626380;
        t1_blk[63:0]    = 64'h18;

        repeat (2) @(negedge clk);
        check("rst s_ready", 512'(s_ready), '0);
        check("rst m_valid", 512'(m_valid), '0);
        check("rst m_block", m_block, '0);
        check("rst m_first", 512'(m_first), '0);
        check("rst m_last", 512'(m_last), '0);
        check("rst busy", 512'(busy), '0);
        rst = 1'b0;
        #1;
        check("post-rst s_ready", 512'(s_ready), 512'(1));

        msg_q = '{8'h61, 8'h62, 8'h63};
        run_msg("T1 abc", 0, 0);
        check("T1 count", 512'(cap_blk.size()), 512'(1));
        check("T1 const", cap_blk[0], t1_blk);

        msg_q.delete();
        run_msg("T2 empty", 0, 0);
        c = '0; c[511:504] = 8'h80;
        check("T2 const", cap_blk[0], c);

        load_msg(56);
        run_msg("T3 56B", 0, 0);
        c = '0; c[63:0] = 64'h1C0;
        check("T3 extra", cap_blk[1], c);

        load_msg(64);
        run_msg("T4 64B", 0, 0);
        c = '0; c[511:504] = 8'h80; c[63:0] = 64'h200;
        check("T4 extra", cap_blk[1], c);

        load_msg(120);
        run_msg("T5 backpressure", 10, 0);

        for (int r = 0; r < 25; r++) begin
            load_msg($urandom_range(0, 200));
            run_msg("rand", -1, 1);
        end

        push_beats(5);
        check("T6 busy before rst", 512'(busy), 512'(1));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("T6 busy after rst", 512'(busy), '0);
        check("T6 m_valid after rst", 512'(m_valid), '0);
        msg_q = '{8'h61, 8'h62, 8'h63};
        run_msg("T6 abc", 0, 0);
        check("T6 const", cap_blk[0], t1_blk);

        push_beats(16);
        check("rst-in-OUT m_valid", 512'(m_valid), 512'(1));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst-in-OUT dropped", 512'(m_valid), '0);
        msg_q = '{8'h61, 8'h62, 8'h63};
        run_msg("rst-in-OUT abc", 0, 0);
        check("rst-in-OUT const", cap_blk[0], t1_blk);

`ifdef SHA_PAD_ABORT_EN
        push_beats(16);
        check("abort m_valid", 512'(m_valid), 512'(1));
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort dropped", 512'(m_valid), '0);
        check("abort busy", 512'(busy), '0);
        msg_q = '{8'h61, 8'h62, 8'h63};
        run_msg("abort abc", 0, 0);
        check("abort const", cap_blk[0], t1_blk);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
